avmm_sdram_slave_port: RTL and testbench
========================================

Name: avmm_sdram_slave_port

Overview:
- Avalon-MM slave (responder) front end that terminates the system console's 32-bit Avalon-MM master and turns its transactions into a valid/ready command stream for the SDRAM controller core.
- Returns read data in order via readdatavalid and supports pipelined reads up to MAX_RD outstanding.
- Applies waitrequest backpressure when the command buffer is full or the read-credit limit is reached.
- Sits between the console interconnect and the SDRAM controller core.

Parameters:
- ADDR_W, 32, Avalon byte-address width.
- DATA_W, 32, data width; BE_W = DATA_W/8.
- MAX_RD, 4, maximum outstanding reads and response FIFO depth; power of two, at least 2.

Ports:
- clk_clk  in  1  sole clock.
- reset_reset  in  1  synchronous, active-high reset.
- slave_address  in  ADDR_W  byte address.
- slave_read  in  1  read request.
- slave_write  in  1  write request.
- slave_writedata  in  DATA_W  write data.
- slave_byteenable  in  BE_W  byte lanes.
- slave_waitrequest  out  1  stall; request accepted when (read|write) && !waitrequest.
- slave_readdata  out  DATA_W  read data.
- slave_readdatavalid  out  1  readdata qualifier.
- core_cmd_valid  out  1  command available.
- core_cmd_ready  in  1  core accepts command.
- core_cmd_we  out  1  1 = write.
- core_cmd_addr  out  ADDR_W-2  word address (slave_address[ADDR_W-1:2]).
- core_cmd_wdata  out  DATA_W  write data.
- core_cmd_be  out  BE_W  byte enables.
- core_rsp_valid  in  1  read data from core (no backpressure).
- core_rsp_data  in  DATA_W  read data.
- status_outstanding  out  clog2(MAX_RD)+1  reads accepted but not yet returned.
- status_err  out  1  sticky protocol error.

Behaviour:
- Reset values: slave_waitrequest=1 while reset_reset is high and 0 on the first idle cycle after it; readdatavalid=0; readdata=0; core_cmd_valid=0; status_outstanding=0; status_err=0; command register and FIFO emptied.
- Command register: one entry holding we, addr, wdata and be. It is full while core_cmd_valid=1 and empties when core_cmd_valid && core_cmd_ready.
- waitrequest (combinational after reset) = cmd_full && !core_cmd_ready, OR (slave_read && !slave_write && status_outstanding==MAX_RD).
- Pass-through: an accepted request loads the register in the same cycle a pop occurs. Sustained throughput is one command per cycle when core_cmd_ready=1.
- Command latency: acceptance at cycle N gives core_cmd_valid at N+1.
- Read and write asserted together: the write is performed, the read is dropped and status_err is set.
- Address bits [1:0] are ignored.
- Credit counter: +1 on each accepted read, -1 on each readdatavalid beat. Both in the same cycle leave it unchanged. It never exceeds MAX_RD.
- Response path: core_rsp_valid pushes core_rsp_data into a FIFO of depth MAX_RD. The FIFO pops whenever it is non-empty, giving readdatavalid and readdata, both registered.
- Response latency: core_rsp_valid at cycle N gives readdatavalid at N+1 when the FIFO is empty; the FIFO is bypass-free. Data order is preserved.
- core_rsp_valid arriving while status_outstanding==0, or while the FIFO is full without a pop: status_err is set and the data is discarded.
- Reset mid-operation clears the command register, FIFO and counter. Pending reads are abandoned; the core shares the same reset.
- status_err clears only on reset.

Decomposition:
- Package avmm_sdram_pkg: ADDR_W/DATA_W defaults, BE_W, and a cmd struct {we, addr, wdata, be}.
- One sub-module, avmm_rsp_fifo: synchronous FIFO with parameters DEPTH and WIDTH and ports push, pop, din, dout, empty, full.

Test Plan:
- Single write, addr 0x0000_0010, data 0xDEADBEEF, be 0xF, core_cmd_ready=1 -> core_cmd_valid at N+1 with we=1, addr=0x4, wdata=0xDEADBEEF; waitrequest stays 0.
- Four back-to-back reads at addr 0x0,0x4,0x8,0xC, core returns 0x11,0x22,0x33,0x44 after 3 cycles -> readdatavalid beats carry 0x11..0x44 in order, one cycle after each core_rsp; a fifth read is stalled by waitrequest until the first beat.
- core_cmd_ready held 0 for 5 cycles during a write burst -> one command is buffered, waitrequest=1 for the second request, and that request is accepted the cycle core_cmd_ready rises with no loss.
- read=write=1 at addr 0x20 -> only a write is issued, status_err=1, status_outstanding unchanged.
- Spurious core_rsp_valid with status_outstanding=0 -> no readdatavalid, status_err=1.
- reset_reset asserted with 2 reads outstanding -> next cycle status_outstanding=0, core_cmd_valid=0, readdatavalid=0, status_err=0.

Source files
------------

// File: rtl/avmm_sdram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avmm_sdram_pkg
// Brief    : Shared widths and the command record for the console-to-SDRAM port.
// Revision : 1.0 - initial release
// ============================================================================
package avmm_sdram_pkg;

    localparam int C_ADDR_W = 32;
    localparam int C_DATA_W = 32;
    localparam int C_BE_W   = C_DATA_W / 8;

    // The command record is sized by the package widths; override both together.
    typedef struct packed {
        logic                  we;
        logic [C_ADDR_W-3:0]   addr;
        logic [C_DATA_W-1:0]   wdata;
        logic [C_BE_W-1:0]     be;
    } cmd_t;

endpackage : avmm_sdram_pkg
`default_nettype wire

// File: rtl/avmm_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : avmm_rsp_fifo
// Brief    : Bypass-free synchronous FIFO holding read responses from the core.
// Revision : 1.0 - initial release
// ============================================================================
module avmm_rsp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is allowed only when an entry leaves in the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign dout  = r_mem[r_rptr[AW-1:0]];

endmodule : avmm_rsp_fifo
`default_nettype wire

// File: rtl/avmm_sdram_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : avmm_sdram_slave_port
// Brief    : Avalon-MM responder turning console transactions into SDRAM core commands.
// Revision : 1.0 - initial release
// ============================================================================
module avmm_sdram_slave_port
    import avmm_sdram_pkg::*;
#(
    parameter  int ADDR_W = C_ADDR_W,
    parameter  int DATA_W = C_DATA_W,
    parameter  int MAX_RD = 4,
    localparam int BE_W   = DATA_W / 8,
    localparam int CNT_W  = $clog2(MAX_RD) + 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,

    input  logic [ADDR_W-1:0] slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [DATA_W-1:0] slave_writedata,
    input  logic [BE_W-1:0]   slave_byteenable,
    output logic              slave_waitrequest,
    output logic [DATA_W-1:0] slave_readdata,
    output logic              slave_readdatavalid,

    output logic              core_cmd_valid,
    input  logic              core_cmd_ready,
    output logic              core_cmd_we,
    output logic [ADDR_W-3:0] core_cmd_addr,
    output logic [DATA_W-1:0] core_cmd_wdata,
    output logic [BE_W-1:0]   core_cmd_be,
    input  logic              core_rsp_valid,
    input  logic [DATA_W-1:0] core_rsp_data,

    output logic [CNT_W-1:0]  status_outstanding,
    output logic              status_err
);

    cmd_t              r_cmd;
    logic              r_cmd_valid;
    logic [CNT_W-1:0]  r_outstanding;
    logic              r_err;

    logic              w_cmd_pop;
    logic              w_rd_limit;
    logic              w_waitreq;
    logic              w_accept;
    logic              w_acc_rd;
    logic              w_both;

    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [DATA_W-1:0] w_fifo_dout;
    logic              w_rsp_err;

    logic              w_unused;

    // Byte-offset bits carry no meaning for a word-wide core.
    assign w_unused = ^slave_address[1:0];

    // ------------------------------------------------------------------
    // Request acceptance and backpressure
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd_pop  = r_cmd_valid && core_cmd_ready;
        w_rd_limit = slave_read && !slave_write && (r_outstanding == CNT_W'(MAX_RD));
        // A full register still takes a new request when it drains this cycle.
        w_waitreq  = reset_reset || (r_cmd_valid && !core_cmd_ready) || w_rd_limit;
        w_accept   = (slave_read || slave_write) && !w_waitreq;
        w_acc_rd   = w_accept && slave_read && !slave_write;
        w_both     = w_accept && slave_read && slave_write;
    end

    // ------------------------------------------------------------------
    // Single-entry command register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_cmd_valid <= 1'b0;
            r_cmd       <= '0;
        end else if (w_accept) begin
            r_cmd_valid <= 1'b1;
            r_cmd.we    <= slave_write;
            r_cmd.addr  <= slave_address[ADDR_W-1:2];
            r_cmd.wdata <= slave_writedata;
            r_cmd.be    <= slave_byteenable;
        end else if (w_cmd_pop) begin
            r_cmd_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    assign w_fifo_pop  = !w_fifo_empty;
    // Data nobody asked for, or that has nowhere to go, is dropped and flagged.
    assign w_rsp_err   = core_rsp_valid &&
                         ((r_outstanding == '0) || (w_fifo_full && !w_fifo_pop));
    assign w_fifo_push = core_rsp_valid && !w_rsp_err;

    avmm_rsp_fifo #(
        .DEPTH (MAX_RD),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (w_fifo_push),
        .pop   (w_fifo_pop),
        .din   (core_rsp_data),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    // ------------------------------------------------------------------
    // Read credit counter and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_outstanding <= '0;
        end else begin
            case ({w_acc_rd, w_fifo_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_err <= 1'b0;
        end else if (w_both || w_rsp_err) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign slave_waitrequest   = w_waitreq;
    assign slave_readdatavalid = w_fifo_pop;
    assign slave_readdata      = w_fifo_pop ? w_fifo_dout : '0;

    assign core_cmd_valid      = r_cmd_valid;
    assign core_cmd_we         = r_cmd.we;
    assign core_cmd_addr       = r_cmd.addr;
    assign core_cmd_wdata      = r_cmd.wdata;
    assign core_cmd_be         = r_cmd.be;

    assign status_outstanding  = r_outstanding;
    assign status_err          = r_err;

endmodule : avmm_sdram_slave_port
`default_nettype wire

// File: tb/tb_avmm_sdram_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_avmm_sdram_slave_port
// Brief    : Scoreboard bench for the console-to-SDRAM Avalon-MM port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avmm_sdram_slave_port;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [31:0] slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [3:0]  slave_byteenable;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;
    logic        core_cmd_valid;
    logic        core_cmd_ready;
    logic        core_cmd_we;
    logic [29:0] core_cmd_addr;
    logic [31:0] core_cmd_wdata;
    logic [3:0]  core_cmd_be;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_data;
    logic [2:0]  status_outstanding;
    logic        status_err;

    logic        auto_v;
    logic [31:0] auto_d;
    logic        man_v;
    logic [31:0] man_d;

    assign core_rsp_valid = auto_v | man_v;
    assign core_rsp_data  = man_v ? man_d : auto_d;

    avmm_sdram_slave_port #(
        .ADDR_W (32),
        .DATA_W (32),
        .MAX_RD (4)
    ) dut (
        .clk_clk             (clk_clk),
        .reset_reset         (reset_reset),
        .slave_address       (slave_address),
        .slave_read          (slave_read),
        .slave_write         (slave_write),
        .slave_writedata     (slave_writedata),
        .slave_byteenable    (slave_byteenable),
        .slave_waitrequest   (slave_waitrequest),
        .slave_readdata      (slave_readdata),
        .slave_readdatavalid (slave_readdatavalid),
        .core_cmd_valid      (core_cmd_valid),
        .core_cmd_ready      (core_cmd_ready),
        .core_cmd_we         (core_cmd_we),
        .core_cmd_addr       (core_cmd_addr),
        .core_cmd_wdata      (core_cmd_wdata),
        .core_cmd_be         (core_cmd_be),
        .core_rsp_valid      (core_rsp_valid),
        .core_rsp_data       (core_rsp_data),
        .status_outstanding  (status_outstanding),
        .status_err          (status_err)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_cmd_t;

    typedef struct {
        int          due;
        logic [31:0] d;
    } rsp_t;

    exp_cmd_t    exp_cmd_q [$];
    logic [31:0] exp_rd_q  [$];
    rsp_t        rsp_q     [$];
    int          m_out = 0;
    logic        exp_rdv = 1'b0;
    int          first_beat_cyc = -1;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Core memory model: each word returns (word_address + 1) * 0x11.
    function automatic logic [31:0] mem_data(input logic [29:0] w);
        return (32'(w) + 32'd1) * 32'h11;
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk_clk) begin
        exp_cmd_t e;
        rsp_t     r;
        if (reset_reset) begin
            exp_cmd_q.delete();
            exp_rd_q.delete();
            m_out   = 0;
            exp_rdv = 1'b0;
        end else begin
            check("rdv_latency", slave_readdatavalid, exp_rdv);
            if (slave_readdatavalid) begin
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                if (exp_rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_data", slave_readdata, exp_rd_q.pop_front());
            end
            exp_rdv = core_rsp_valid && (m_out != 0);

            if (core_cmd_valid && core_cmd_ready) begin
                if (exp_cmd_q.size() == 0) begin
                    check("cmd_unexpected", 1, 0);
                end else begin
                    e = exp_cmd_q.pop_front();
                    check("cmd_we", core_cmd_we, e.we);
                    check("cmd_addr", core_cmd_addr, e.addr);
                    if (e.we) begin
                        check("cmd_wdata", core_cmd_wdata, e.wdata);
                        check("cmd_be", core_cmd_be, e.be);
                    end
                end
                if (!core_cmd_we) begin
                    r.due = cyc + 3;
                    r.d   = mem_data(core_cmd_addr);
                    rsp_q.push_back(r);
                end
            end

            if ((slave_read || slave_write) && !slave_waitrequest) begin
                e.we    = slave_write;
                e.addr  = slave_address[31:2];
                e.wdata = slave_writedata;
                e.be    = slave_byteenable;
                exp_cmd_q.push_back(e);
                if (slave_read && !slave_write) begin
                    exp_rd_q.push_back(mem_data(slave_address[31:2]));
                    m_out++;
                end
            end
            if (slave_readdatavalid) m_out--;
        end
    end

    // Core responder: returns read data three cycles after the command handshake.
    initial begin
        auto_v = 1'b0;
        auto_d = '0;
        forever begin
            @(posedge clk_clk);
            #1;
            auto_v = 1'b0;
            if (!reset_reset && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                auto_v = 1'b1;
                auto_d = rsp_q[0].d;
                void'(rsp_q.pop_front());
            end
        end
    end

    // Call just after a rising edge; returns just after the edge that accepted the request.
    task automatic avm_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be,
                           output int acc_cyc, output int stalls);
        slave_read       = rd;
        slave_write      = wr;
        slave_address    = addr;
        slave_writedata  = data;
        slave_byteenable = be;
        stalls  = 0;
        acc_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_clk);
            if (!slave_waitrequest) begin
                acc_cyc = cyc;
                break;
            end
            stalls++;
        end
        if (acc_cyc < 0) check("req_timeout", 0, 1);
        @(posedge clk_clk);
        #1;
        slave_read  = 1'b0;
        slave_write = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_clk);
            if (exp_rd_q.size() == 0 && exp_cmd_q.size() == 0 && rsp_q.size() == 0 &&
                m_out == 0 && !core_cmd_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 0, 1);
        check("drain_outstanding", status_outstanding, 0);
        @(posedge clk_clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_reset = 1'b1;
        rsp_q.delete();
        repeat (2) @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
    endtask

    initial begin
        int acc, st, acc_a, st_a, acc_b, st_b, rdy_cyc;
        reset_reset      = 1'b1;
        slave_address    = '0;
        slave_read       = 1'b0;
        slave_write      = 1'b0;
        slave_writedata  = '0;
        slave_byteenable = '0;
        core_cmd_ready   = 1'b1;
        man_v            = 1'b0;
        man_d            = '0;
        rdy_cyc          = -1;

        // Reset state
        repeat (2) @(posedge clk_clk);
        @(negedge clk_clk);
        check("rst_waitreq", slave_waitrequest, 1);
        check("rst_rdv", slave_readdatavalid, 0);
        check("rst_rdata", slave_readdata, 0);
        check("rst_cmd_valid", core_cmd_valid, 0);
        check("rst_outstanding", status_outstanding, 0);
        check("rst_err", status_err, 0);
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        @(negedge clk_clk);
        check("rst_release_waitreq", slave_waitrequest, 0);
        @(posedge clk_clk);
        #1;

        // Single write, one-cycle command latency
        avm_req(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, acc, st);
        check("wr1_stalls", st, 0);
        @(negedge clk_clk);
        check("wr1_cmd_valid", core_cmd_valid, 1);
        check("wr1_cmd_we", core_cmd_we, 1);
        check("wr1_cmd_addr", core_cmd_addr, 30'h4);
        check("wr1_cmd_wdata", core_cmd_wdata, 32'hDEAD_BEEF);
        @(posedge clk_clk);
        #1;
        wait_idle();

        // Four pipelined reads, then a fifth held off by the credit limit
        first_beat_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            avm_req(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'hF, acc, st);
            check("rd_burst_stalls", st, 0);
        end
        check("rd_credit_full", status_outstanding, 4);
        avm_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, acc, st);
        check("rd5_was_stalled", (st > 0), 1);
        check("rd5_accept_cycle", acc, first_beat_cyc + 1);
        wait_idle();

        // Core backpressure during a write burst
        core_cmd_ready = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk_clk);
                #1;
                core_cmd_ready = 1'b1;
                rdy_cyc = cyc;
            end
            begin
                avm_req(1'b0, 1'b1, 32'h0000_0100, 32'hA5A5_0001, 4'hF, acc_a, st_a);
                avm_req(1'b0, 1'b1, 32'h0000_0104, 32'h5A5A_0002, 4'h3, acc_b, st_b);
            end
        join
        check("bp_first_stalls", st_a, 0);
        check("bp_second_stalled", (st_b > 0), 1);
        check("bp_second_accept_cycle", acc_b, rdy_cyc);
        wait_idle();

        // Read and write together: write issued, read dropped, error flagged
        avm_req(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_0001, 4'hF, acc, st);
        @(negedge clk_clk);
        check("rw_cmd_we", core_cmd_we, 1);
        check("rw_err", status_err, 1);
        check("rw_outstanding", status_outstanding, 0);
        @(posedge clk_clk);
        #1;
        wait_idle();

        // Spurious response with no reads outstanding
        pulse_reset();
        @(negedge clk_clk);
        check("err_cleared", status_err, 0);
        @(posedge clk_clk);
        #1;
        man_v = 1'b1;
        man_d = 32'h0000_0099;
        @(posedge clk_clk);
        #1;
        man_v = 1'b0;
        @(negedge clk_clk);
        check("spur_rdv", slave_readdatavalid, 0);
        check("spur_err", status_err, 1);
        @(posedge clk_clk);
        #1;

        // Reset with two reads in flight
        avm_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, acc, st);
        avm_req(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'hF, acc, st);
        reset_reset = 1'b1;
        rsp_q.delete();
        @(negedge clk_clk);
        check("mid_pre_outstanding", status_outstanding, 2);
        @(negedge clk_clk);
        check("mid_outstanding", status_outstanding, 0);
        check("mid_cmd_valid", core_cmd_valid, 0);
        check("mid_rdv", slave_readdatavalid, 0);
        check("mid_err", status_err, 0);
        check("mid_waitreq", slave_waitrequest, 1);
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        repeat (8) @(posedge clk_clk);
        @(negedge clk_clk);
        check("end_rd_queue", exp_rd_q.size(), 0);
        check("end_cmd_queue", exp_cmd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_avmm_sdram_slave_port
`default_nettype wire
